// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU between decode and writeback in the multi-cycle core.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA) give a
// registered result one cycle after acceptance. Codes 14-15 return
// DEFAULT_RES.
//
// Optional feature macro: ALU_MULDIV_EN
//   defined     - codes 10-13 (MUL, MULHU, DIVU, REMU) run iteratively,
//                 one bit per cycle, for WIDTH cycles.
//   not defined - codes 10-13 behave as undefined codes and busy is tied 0.
//
// Parameters:
//   WIDTH        operand/result width (power of two, >= 8)
//   DEFAULT_RES  result for undefined codes, truncated/zero-extended to WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/control valid
//   in_ready   block can accept an operation this cycle
//   srcA/srcB  operands
//   control    operation select
//   out_valid  result/z valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   z          registered (result == 0)
//   busy       multi-cycle operation in progress
module alu_seq #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] DEFAULT_RES = 32'hDEADCAFE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             busy
);

    localparam int               SW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DEF_RES = WIDTH'(DEFAULT_RES);

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] simpleRes;

    assign shamt  = srcB[SW-1:0];
    assign accept = in_valid & in_ready;

    // Result of every single-cycle operation, computed straight from the
    // input operands so it can be loaded on the accepting edge. Anything
    // that is not a single-cycle code falls through to the default result.
    always_comb begin
        simpleRes = DEF_RES;
        case (control)
            4'd0:    simpleRes = srcA + srcB;
            4'd1:    simpleRes = srcA - srcB;
            4'd2:    simpleRes = srcA & srcB;
            4'd3:    simpleRes = srcA | srcB;
            4'd4:    simpleRes = srcA ^ srcB;
            4'd5:    simpleRes = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'd6:    simpleRes = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            4'd7:    simpleRes = srcA << shamt;
            4'd8:    simpleRes = srcA >> shamt;
            4'd9:    simpleRes = $signed(srcA) >>> shamt;
            default: simpleRes = DEF_RES;
        endcase
    end

`ifdef ALU_MULDIV_EN

    typedef enum logic [1:0] {IDLE, MUL, DIV} StateType;

    StateType           state;
    logic [SW-1:0]      count;
    logic               high;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divTake;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] stepNext;
    logic [WIDTH-1:0]   finalRes;

    // One iteration of either long operation. The work register is shared:
    // for multiply it holds {partial high half, remaining multiplier bits},
    // for divide it holds {partial remainder, dividend bits still to shift
    // in / quotient bits shifted in}. operand is the multiplicand or the
    // divisor. A zero divisor always "fits", so the quotient fills with ones
    // and the dividend ends up in the remainder without special handling.
    always_comb begin
        mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        mulNext  = {mulSum, work[WIDTH-1:1]};
        divShift = work[2*WIDTH-1:WIDTH-1];
        divDiff  = divShift - {1'b0, operand};
        divTake  = (divShift >= {1'b0, operand});
        divNext  = {(divTake ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]), work[WIDTH-2:0], divTake};
        stepNext = (state == DIV) ? divNext : mulNext;
        finalRes = high ? stepNext[2*WIDTH-1:WIDTH] : stepNext[WIDTH-1:0];
    end

    // Control FSM and output register. In IDLE an accepted simple op loads
    // the result straight away, while MUL/MULHU/DIVU/REMU capture their
    // operands and iterate. high selects the upper half of the work
    // register at the end (MULHU product high, REMU remainder). A new load
    // takes priority over the consumer clearing out_valid, which lets a
    // fresh result replace a consumed one on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            high      <= 1'b0;
            operand   <= '0;
            work      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (control)
                            4'd10, 4'd11: begin
                                state   <= MUL;
                                operand <= srcA;
                                work    <= {{WIDTH{1'b0}}, srcB};
                                high    <= (control == 4'd11);
                                count   <= '0;
                            end
                            4'd12, 4'd13: begin
                                state   <= DIV;
                                operand <= srcB;
                                work    <= {{WIDTH{1'b0}}, srcA};
                                high    <= (control == 4'd13);
                                count   <= '0;
                            end
                            default: begin
                                result    <= simpleRes;
                                z         <= (simpleRes == '0);
                                out_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL, DIV: begin
                    work  <= stepNext;
                    count <= count + SW'(1);
                    if (count == SW'(WIDTH-1)) begin
                        state     <= IDLE;
                        result    <= finalRes;
                        z         <= (finalRes == '0);
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign in_ready = rst_n & (state == IDLE) & (~out_valid | out_ready);

`else

    // Output register for the single-cycle-only build: load on acceptance,
    // clear when the consumer takes the result, with load winning so a new
    // result can follow a consumed one back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                result    <= simpleRes;
                z         <= (simpleRes == '0);
                out_valid <= 1'b1;
            end
        end
    end

    assign busy     = 1'b0;
    assign in_ready = rst_n & (~out_valid | out_ready);

`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH = 32).
// Inputs are driven and outputs sampled around the falling clock edge.
// Long-operation vectors are compiled in when ALU_MULDIV_EN is defined;
// otherwise codes 10-13 are checked as undefined codes.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    alu_seq #(
        .WIDTH       (32),
        .DEFAULT_RES (32'hDEADCAFE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .srcA      (srcA),
        .srcB      (srcB),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .busy      (busy)
    );

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one operation across a single rising edge, then scramble the
    // operand inputs so a design that does not capture them would misbehave.
    // Entered and left just after a falling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        srcA     = a;
        srcB     = b;
        control  = op;
        in_valid = 1'b1;
        #1;
        checkOutput("in_ready at accept", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        srcA     = 32'h5A5A_5A5A;
        srcB     = 32'hA5A5_A5A5;
        control  = 4'd4;
    endtask

    // Single-cycle op: result must be present in cycle 1
    task automatic runSimple(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, input logic [31:0] expRes, input logic expZ);
        applyStimulus(a, b, op);
        checkOutput({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, " result"}, result, expRes);
        checkOutput({tag, " z"}, {31'b0, z}, {31'b0, expZ});
        checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
    endtask

`ifdef ALU_MULDIV_EN
    // Long op: busy for exactly 32 cycles, in_ready low meanwhile, result
    // valid in cycle 33. The wait is bounded so a stuck design still ends.
    task automatic runLong(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] expRes);
        int cyc;
        int busyCycles;
        int readyLeaks;
        applyStimulus(a, b, op);
        cyc        = 1;
        busyCycles = 0;
        readyLeaks = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) busyCycles++;
            if (in_ready) readyLeaks++;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, " latency"}, cyc, 32'd33);
        checkOutput({tag, " busy cycles"}, busyCycles, 32'd32);
        checkOutput({tag, " in_ready while busy"}, readyLeaks, 32'd0);
        checkOutput({tag, " result"}, result, expRes);
        checkOutput({tag, " z"}, {31'b0, z}, {31'b0, (expRes == 32'd0)});
        checkOutput({tag, " busy after"}, {31'b0, busy}, 32'd0);
    endtask
`endif

    // Main directed sequence
    initial begin
        int leaks;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        srcA      = '0;
        srcB      = '0;
        control   = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset z", {31'b0, z}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after release", {31'b0, in_ready}, 32'd1);

        runSimple("ADD 7,5",        32'd7,          32'd5,          4'd0,  32'd12,         1'b0);
        runSimple("SUB 5,5",        32'd5,          32'd5,          4'd1,  32'd0,          1'b1);
        runSimple("SUB 0,1",        32'd0,          32'd1,          4'd1,  32'hFFFF_FFFF,  1'b0);
        runSimple("ADD wrap",       32'hFFFF_FFFF,  32'd1,          4'd0,  32'd0,          1'b1);
        runSimple("AND",            32'hF0F0_1234,  32'h0FF0_FF00,  4'd2,  32'h00F0_1200,  1'b0);
        runSimple("OR",             32'hF000_0000,  32'h0000_000F,  4'd3,  32'hF000_000F,  1'b0);
        runSimple("XOR",            32'hA5A5_A5A5,  32'hFFFF_FFFF,  4'd4,  32'h5A5A_5A5A,  1'b0);
        runSimple("SLT -1,1",       32'hFFFF_FFFF,  32'd1,          4'd5,  32'd1,          1'b0);
        runSimple("SLTU max,1",     32'hFFFF_FFFF,  32'd1,          4'd6,  32'd0,          1'b1);
        runSimple("SLTU 1,max",     32'd1,          32'hFFFF_FFFF,  4'd6,  32'd1,          1'b0);
        runSimple("SLL 1 by 33",    32'd1,          32'd33,         4'd7,  32'd2,          1'b0);
        runSimple("SRL",            32'h8000_0000,  32'd4,          4'd8,  32'h0800_0000,  1'b0);
        runSimple("SRA neg",        32'h8000_0000,  32'h24,         4'd9,  32'hF800_0000,  1'b0);
        runSimple("SRA pos",        32'h4000_0000,  32'd4,          4'd9,  32'h0400_0000,  1'b0);
        runSimple("code 14",        32'd1,          32'd2,          4'd14, 32'hDEAD_CAFE,  1'b0);
        runSimple("code 15",        32'd1,          32'd2,          4'd15, 32'hDEAD_CAFE,  1'b0);

        @(negedge clk);
        checkOutput("out_valid drops after take", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
        runLong("MUL 0x10000^2",   32'h0001_0000, 32'h0001_0000, 4'd10, 32'd0);
        runLong("MULHU 0x10000^2", 32'h0001_0000, 32'h0001_0000, 4'd11, 32'd1);
        runLong("MUL 6*7",         32'd6,         32'd7,         4'd10, 32'd42);
        runLong("MULHU max*max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'hFFFF_FFFE);
        runLong("DIVU 100,7",      32'd100,       32'd7,         4'd12, 32'd14);
        runLong("REMU 100,7",      32'd100,       32'd7,         4'd13, 32'd2);
        runLong("DIVU 100,0",      32'd100,       32'd0,         4'd12, 32'hFFFF_FFFF);
        runLong("REMU 100,0",      32'd100,       32'd0,         4'd13, 32'd100);
`else
        runSimple("code 10 undef", 32'd3, 32'd4, 4'd10, 32'hDEAD_CAFE, 1'b0);
        runSimple("code 11 undef", 32'd3, 32'd4, 4'd11, 32'hDEAD_CAFE, 1'b0);
        runSimple("code 12 undef", 32'd3, 32'd4, 4'd12, 32'hDEAD_CAFE, 1'b0);
        runSimple("code 13 undef", 32'd3, 32'd4, 4'd13, 32'hDEAD_CAFE, 1'b0);
`endif

        // Backpressure: result held, queued op waits until the consumer takes it
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(32'd1, 32'd2, 4'd0);
        srcA     = 32'd9;
        srcB     = 32'd4;
        control  = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp result held", result, 32'd3);
            checkOutput("bp out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp in_ready on release", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp queued result", result, 32'd5);
        checkOutput("bp queued out_valid", {31'b0, out_valid}, 32'd1);

        // Reset in cycle 10 of an operation
        @(negedge clk);
`ifdef ALU_MULDIV_EN
        applyStimulus(32'd100, 32'd7, 4'd12);
`else
        out_ready = 1'b0;
        applyStimulus(32'd3, 32'd4, 4'd0);
`endif
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midop reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midop reset result", result, 32'd0);
        checkOutput("midop reset z", {31'b0, z}, 32'd0);
        checkOutput("midop reset busy", {31'b0, busy}, 32'd0);
        checkOutput("midop reset in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("in_ready after midop reset", {31'b0, in_ready}, 32'd1);
        leaks = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) leaks++;
        end
        checkOutput("no out_valid after abort", leaks, 32'd0);
        runSimple("ADD 2,2 after reset", 32'd2, 32'd2, 4'd0, 32'd4, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath ALU. Single-cycle ops (add/sub/logic/compare/shift) return a registered result one cycle after acceptance. Optional iterative multiply/divide ops take WIDTH cycles. Sits between decode and writeback in the multi-cycle core, with valid/ready on both sides so the control FSM can stall on long ops.

## Interface
- WIDTH, 32: operand/result width; must be a power of two ≥ 8.
- DEFAULT_RES, 32'hDEADCAFE: result for undefined control codes, truncated/zero-extended to WIDTH.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operands/control valid
- in_ready  out  1  block can accept an operation this cycle
- srcA  in  WIDTH  operand A
- srcB  in  WIDTH  operand B
- control  in  4  operation select
- out_valid  out  1  result/z valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- z  out  1  registered (result == 0)
- busy  out  1  multi-cycle op in progress

## Operation
- Codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU: result is 0 or 1, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA: shift amount = srcB[$clog2(WIDTH)-1:0], upper bits ignored.
  - 10 MUL (low WIDTH bits of product), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIVU, 13 REMU.
  - 14–15 → DEFAULT_RES.
- Acceptance: in_valid & in_ready at a rising edge; operands and control are captured, and later input changes are ignored.
- in_ready = (state==IDLE) & (!out_valid | out_ready); forced 0 while rst_n low.
- FSM states:
  - IDLE: simple op → load result, go to or stay in IDLE; MUL/MULHU → MUL; DIVU/REMU → DIV.
  - MUL: shift-add, one multiplier bit per cycle; counter runs 0..WIDTH-1; on last step load result, go to IDLE.
  - DIV: restoring, one quotient bit per cycle; same counter; on last step load result, go to IDLE.
- Divide by zero: DIVU → all ones; REMU → srcA; still takes WIDTH cycles.
- Output register: result and z load together with out_valid=1. Held stable until out_valid & out_ready. With in_ready high, a new result may load in the same cycle the old one is consumed.
- busy = (state != IDLE).
- Reset values: out_valid 0, result 0, z 0, busy 0, state IDLE, counter 0.
- Reset mid-operation aborts; partial results are discarded and no out_valid is produced.

## Timing
- Handshake in cycle 0:
  - Simple op: out_valid high from cycle 1.
  - MUL/DIV: busy high in cycles 1..WIDTH; out_valid high from cycle WIDTH+1.
- Throughput with out_ready tied high: one simple op per cycle; one mul/div per WIDTH+1 cycles.
- in_ready is low throughout MUL/DIV states and while an unconsumed result is held.
- in_ready is 1 in the first cycle after rst_n deasserts.

## Configuration
- ALU_MULDIV_EN defined: codes 10–13 are iterative as above; MUL/DIV states, datapath and counter are present.
- Not defined: MUL/DIV logic is absent; codes 10–13 behave as undefined and return DEFAULT_RES with 1-cycle latency; busy is tied 0.

## Test plan
- ADD 7,5 → result 12, z 0, out_valid in cycle 1. Then SUB 5,5 → 0, z 1.
- SLT 0xFFFFFFFF,1 → 1; SLTU same → 0; SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000; control 14 → 0xDEADCAFE.
- With ALU_MULDIV_EN defined:
  - MUL 0x10000,0x10000 → 0, z 1; MULHU same → 1.
  - busy high for exactly 32 cycles; out_valid in cycle 33.
- DIVU 100,7 → 14; REMU 100,7 → 2; DIVU 100,0 → 0xFFFFFFFF; REMU 100,0 → 100.
- Backpressure: ADD 1,2 with out_ready=0 for 5 cycles → result 3 held, in_ready 0, pending in_valid not accepted. When out_ready rises, the queued op is accepted the same cycle and its result appears next cycle.
- Assert rst_n=0 in cycle 10 of a DIVU → all outputs reset at once, no out_valid after release, in_ready 1 next cycle, subsequent ADD 2,2 → 4. Without ALU_MULDIV_EN, control 10 → 0xDEADCAFE in cycle 1.
